// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: clocked, back-pressurable front end for the combinational ALU.
// Accepts a request, holds the ALU inputs for SETTLE_CYCLES, captures the ALU
// result/error into a response register, and keeps saturating error counters.
// Optional build macro: ALU_CHAIN_EN adds req_chain, which feeds the previous
// captured result[15:0] into operand A.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | waiting for a request, req_ready high
// SETTLE | ALU inputs held, settle down-counter running
// RESP   | response presented until rsp_ready
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [15:0]       req_a,
  input  logic [15:0]       req_b,
  input  logic [3:0]        req_cmd,
`ifdef ALU_CHAIN_EN
  input  logic              req_chain,
`endif
  output logic [15:0]       alu_a,
  output logic [15:0]       alu_b,
  output logic [3:0]        alu_cmd,
  input  logic [31:0]       alu_result,
  input  logic [1:0]        alu_error,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_result,
  output logic [1:0]        rsp_error,
  output logic [3:0]        rsp_cmd,
  output logic              busy,
  output logic [CNT_W-1:0]  ovf_count,
  output logic [CNT_W-1:0]  dbz_count,
  input  logic              clr_counts
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   settle_cnt;
  logic            accept;
  logic            capture;
  logic            release_rsp;
  logic [15:0]     next_a;

  assign req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
  assign busy      = (state != IDLE);

`ifdef ALU_CHAIN_EN
  assign next_a = req_chain ? rsp_result[15:0] : req_a;
`else
  assign next_a = req_a;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and datapath strobes
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    capture     = 1'b0;
    release_rsp = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == '0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          release_rsp = 1'b1;
          if (req_valid) begin
            accept    = 1'b1;
            state_nxt = SETTLE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Settle window down-counter, terminal count at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if (accept) begin
      settle_cnt <= SETTLE_LOAD;
    end else if ((state == SETTLE) && (settle_cnt != '0)) begin
      settle_cnt <= settle_cnt - SW'(1);
    end
  end

  // ALU input registers; hold last issued operands after capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_cmd <= '0;
    end else if (accept) begin
      alu_a   <= next_a;
      alu_b   <= req_b;
      alu_cmd <= req_cmd;
    end
  end

  // Response register, stable while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_error  <= '0;
      rsp_cmd    <= '0;
    end else if (capture) begin
      rsp_valid  <= 1'b1;
      rsp_result <= alu_result;
      rsp_error  <= alu_error;
      rsp_cmd    <= alu_cmd;
    end else if (release_rsp) begin
      rsp_valid  <= 1'b0;
    end
  end

  // Saturating overflow counter; clear overrides a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (clr_counts) begin
      ovf_count <= '0;
    end else if (capture && alu_error[0] && (ovf_count != CNT_MAX)) begin
      ovf_count <= ovf_count + CNT_W'(1);
    end
  end

  // Saturating divide-by-zero counter; clear overrides a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbz_count <= '0;
    end else if (clr_counts) begin
      dbz_count <= '0;
    end else if (capture && alu_error[1] && (dbz_count != CNT_MAX)) begin
      dbz_count <= dbz_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer with a behavioural ALU stand-in.
module tb_alu_op_sequencer;

  localparam int S    = 2;
  localparam int CW   = 2;
  localparam int CMAX = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [15:0]   req_a = '0;
  logic [15:0]   req_b = '0;
  logic [3:0]    req_cmd = '0;
  logic          req_chain = 1'b0;
  logic [15:0]   alu_a, alu_b;
  logic [3:0]    alu_cmd;
  logic [31:0]   alu_result;
  logic [1:0]    alu_error;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_result;
  logic [1:0]    rsp_error;
  logic [3:0]    rsp_cmd;
  logic          busy;
  logic [CW-1:0] ovf_count, dbz_count;
  logic          clr_counts = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int m_ovf = 0;
  int m_dbz = 0;
  logic [15:0] m_last = '0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.SETTLE_CYCLES(S), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cmd(req_cmd),
`ifdef ALU_CHAIN_EN
    .req_chain(req_chain),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
    .alu_result(alu_result), .alu_error(alu_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_error(rsp_error), .rsp_cmd(rsp_cmd),
    .busy(busy), .ovf_count(ovf_count), .dbz_count(dbz_count),
    .clr_counts(clr_counts)
  );

  // ALU behaviour: {error[1:0], result[31:0]}; overflow = signed 16-bit range exceeded
  function automatic logic [33:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] cmd);
    int sa, sb, s;
    logic [31:0] r;
    logic [1:0]  e;
    sa = int'($signed(a));
    sb = int'($signed(b));
    s = 0; r = '0; e = '0;
    case (cmd)
      4'd1: s = sa + sb;
      4'd2: s = sa - sb;
      4'd3: s = sa * sb;
      default: s = 0;
    endcase
    if (cmd >= 4'd1 && cmd <= 4'd3) begin
      r = 32'(s);
      e[0] = (s > 32767) || (s < -32768);
    end else if (cmd == 4'd4 || cmd == 4'd5) begin
      if (b == 16'd0) e[1] = 1'b1;
      else if (cmd == 4'd4) r = {16'h0, a / b};
      else r = {16'h0, a % b};
    end
    return {e, r};
  endfunction

  assign {alu_error, alu_result} = alu_fn(alu_a, alu_b, alu_cmd);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic bump_model(input logic [1:0] e);
    if (e[0] && m_ovf < CMAX) m_ovf++;
    if (e[1] && m_dbz < CMAX) m_dbz++;
  endtask

  // Full transaction: issue, check settle window and capture against the model, consume
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] cmd,
                        input logic chain, input int hold,
                        output logic [31:0] res, output logic [1:0] err);
    logic [15:0] ea;
    logic [33:0] exp;
    int n;
    ea  = chain ? m_last : a;
    exp = alu_fn(ea, b, cmd);
    req_valid = 1'b1; req_a = a; req_b = b; req_cmd = cmd; req_chain = chain;
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready_before_accept", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_chain = 1'b0;
    check("busy_settle", {31'h0, busy}, 32'h1);
    check("alu_a_issued", {16'h0, alu_a}, {16'h0, ea});
    check("alu_b_issued", {16'h0, alu_b}, {16'h0, b});
    check("alu_cmd_issued", {28'h0, alu_cmd}, {28'h0, cmd});
    wait_rsp(n);
    check("rsp_latency", 32'(n), 32'(S));
    bump_model(exp[33:32]);
    check("rsp_result_model", rsp_result, exp[31:0]);
    check("rsp_error_model", {30'h0, rsp_error}, {30'h0, exp[33:32]});
    check("rsp_cmd_echo", {28'h0, rsp_cmd}, {28'h0, cmd});
    check("ovf_count_model", {30'h0, ovf_count}, 32'(m_ovf));
    check("dbz_count_model", {30'h0, dbz_count}, 32'(m_dbz));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'h0, rsp_valid}, 32'h1);
      check("hold_result", rsp_result, exp[31:0]);
      check("hold_req_ready", {31'h0, req_ready}, 32'h0);
      check("hold_busy", {31'h0, busy}, 32'h1);
    end
    res = rsp_result;
    err = rsp_error;
    rsp_ready = 1'b1;
    #1;
    check("req_ready_on_rsp_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_valid_cleared", {31'h0, rsp_valid}, 32'h0);
    check("busy_cleared", {31'h0, busy}, 32'h0);
    m_last = exp[15:0];
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alu_a"}, {16'h0, alu_a}, 32'h0);
    check({tag, "_alu_b"}, {16'h0, alu_b}, 32'h0);
    check({tag, "_alu_cmd"}, {28'h0, alu_cmd}, 32'h0);
    check({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
    check({tag, "_rsp_result"}, rsp_result, 32'h0);
    check({tag, "_rsp_error"}, {30'h0, rsp_error}, 32'h0);
    check({tag, "_rsp_cmd"}, {28'h0, rsp_cmd}, 32'h0);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_ovf"}, {30'h0, ovf_count}, 32'h0);
    check({tag, "_dbz"}, {30'h0, dbz_count}, 32'h0);
    check({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  cmd;
    logic [31:0] exp_res;
    logic [1:0]  exp_err;
    int          exp_ovf;
    int          exp_dbz;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] res;
    logic [1:0]  err;
    int n;
    bit seen;

    vecs[0] = '{16'd249,   16'd69,    4'd1, 32'd318,        2'b00, 0, 0};
    vecs[1] = '{16'd249,   16'd69,    4'd2, 32'd180,        2'b00, 0, 0};
    vecs[2] = '{16'd249,   16'd69,    4'd3, 32'd17181,      2'b00, 0, 0};
    vecs[3] = '{16'd249,   16'd69,    4'd4, 32'd3,          2'b00, 0, 0};
    vecs[4] = '{16'd249,   16'd69,    4'd5, 32'd42,         2'b00, 0, 0};
    vecs[5] = '{16'd32000, 16'd16001, 4'd1, 32'h0000BB81,   2'b01, 1, 0};
    vecs[6] = '{16'd100,   16'd0,     4'd4, 32'd0,          2'b10, 1, 1};
    vecs[7] = '{16'd249,   16'd69,    4'd7, 32'd0,          2'b00, 1, 1};

    // reset state
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed vectors
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cmd, 1'b0, i % 3, res, err);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
      check($sformatf("vec%0d_error", i), {30'h0, err}, {30'h0, vecs[i].exp_err});
      check($sformatf("vec%0d_ovf", i), {30'h0, ovf_count}, 32'(vecs[i].exp_ovf));
      check($sformatf("vec%0d_dbz", i), {30'h0, dbz_count}, 32'(vecs[i].exp_dbz));
    end

    // backpressure with a waiting request, then same-edge handoff
    req_valid = 1'b1; req_a = 16'd249; req_b = 16'd69; req_cmd = 4'd3;
    @(posedge clk); #1;
    req_a = 16'd1000; req_b = 16'd3; req_cmd = 4'd1;
    wait_rsp(n);
    check("bp_latency", 32'(n), 32'(S));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_req_ready", {31'h0, req_ready}, 32'h0);
      check("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check("bp_rsp_result", rsp_result, 32'd17181);
      check("bp_rsp_cmd", {28'h0, rsp_cmd}, 32'd3);
      check("bp_alu_a_unchanged", {16'h0, alu_a}, 32'd249);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_req_ready_release", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b0;
    check("bp_handoff_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("bp_handoff_busy", {31'h0, busy}, 32'h1);
    check("bp_handoff_alu_a", {16'h0, alu_a}, 32'd1000);
    check("bp_handoff_alu_cmd", {28'h0, alu_cmd}, 32'd1);
    wait_rsp(n);
    check("bp2_latency", 32'(n), 32'(S));
    check("bp2_result", rsp_result, 32'd1003);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    m_last = 16'd1003;

    // overflow counter saturation
    for (int i = 0; i < 5; i++) run_op(16'd32000, 16'd16001, 4'd1, 1'b0, 0, res, err);
    check("ovf_saturated", {30'h0, ovf_count}, 32'd3);

    // clear coincident with an overflow capture
    req_valid = 1'b1; req_a = 16'd32000; req_b = 16'd16001; req_cmd = 4'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (S - 1) @(posedge clk);
    #1;
    clr_counts = 1'b1;
    @(posedge clk); #1;
    clr_counts = 1'b0;
    check("clr_capture_valid", {31'h0, rsp_valid}, 32'h1);
    check("clr_wins_ovf", {30'h0, ovf_count}, 32'h0);
    check("clr_wins_dbz", {30'h0, dbz_count}, 32'h0);
    m_ovf = 0; m_dbz = 0; m_last = 16'hBB81;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      logic [3:0]  rc;
      logic        rch;
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
      rc  = 4'($urandom_range(0, 15));
`ifdef ALU_CHAIN_EN
      rch = 1'($urandom_range(0, 1));
`else
      rch = 1'b0;
`endif
      run_op(ra, rb, rc, rch, $urandom_range(0, 3), res, err);
    end

`ifdef ALU_CHAIN_EN
    run_op(16'd12, 16'd10, 4'd3, 1'b0, 0, res, err);
    check("chain_mul", res, 32'd120);
    run_op(16'd999, 16'd5, 4'd1, 1'b1, 0, res, err);
    check("chain_alu_a", {16'h0, alu_a}, 32'd120);
    check("chain_add", res, 32'd125);
`endif

    // reset during SETTLE discards the operation
    run_op(16'd32000, 16'd16001, 4'd1, 1'b0, 0, res, err);
    req_valid = 1'b1; req_a = 16'd7; req_b = 16'd9; req_cmd = 4'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("pre_reset_busy", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midop_reset");
    m_ovf = 0; m_dbz = 0; m_last = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < S + 6; i++) begin
      @(posedge clk); #1;
      if (rsp_valid || busy) seen = 1'b1;
    end
    check("no_rsp_after_reset", {31'h0, seen}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
